// File: rtl/hiscore_ram_arbiter.sv
// Lends the single-port game RAM to the hiscore engine: pause the core, let the bus settle, serve byte accesses, release after an idle hold-off.
// Optional pause-length watchdog: define HISCORE_ARB_WATCHDOG_EN.
module hiscore_ram_arbiter #(
  parameter int          AW        = 10,
  parameter int          SETTLE    = 4,
  parameter int          RD_LAT    = 1,
  parameter int          IDLE_HOLD = 8,
  parameter logic [15:0] WD_LIMIT  = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_we,
  output logic [7:0]    cpu_dout,
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [7:0]    hs_wdata,
  output logic          hs_ack,
  output logic [7:0]    hs_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  output logic          pause_cpu,
  output logic          busy,
  output logic          wd_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_GRANT, S_ACCESS, S_ACK, S_RELEASE
  } state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);
  localparam logic [7:0] RD_LD     = 8'(RD_LAT - 1);
  localparam logic [7:0] IDLE_LD   = 8'(IDLE_HOLD - 1);

  state_t        state, state_nx;
  logic [7:0]    cnt, cnt_nx;
  logic          sel_hs;
  logic          paused;
  logic          req_ok;
  logic          wd_trip;
  logic          wr_first;
  logic          rd_done;
  logic [AW-1:0] addr_l;
  logic [7:0]    wdata_l;
  logic          we_l;
  logic [7:0]    rdata_q;

  assign paused = (state == S_PAUSE) || (state == S_GRANT) ||
                  (state == S_ACCESS) || (state == S_ACK);

`ifdef HISCORE_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        wd_err_q;
  logic        wd_block;

  // After a watchdog release the request must be seen low once before it is honoured again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b0;
      wd_block <= 1'b0;
    end else begin
      wd_cnt <= paused ? wd_cnt + 16'd1 : '0;
      if (wd_trip) begin
        wd_err_q <= 1'b1;
        wd_block <= 1'b1;
      end else if (!hs_req) begin
        wd_block <= 1'b0;
      end
    end
  end

  assign wd_trip  = paused && (wd_cnt == WD_LIMIT - 16'd1);
  assign wd_error = wd_err_q;
  assign req_ok   = hs_req && !wd_block;
`else
  assign wd_trip  = 1'b0;
  assign wd_error = 1'b0;
  assign req_ok   = hs_req;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sel_hs  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      sel_hs <= (state_nx == S_GRANT) || (state_nx == S_ACCESS) || (state_nx == S_ACK);
      if (rd_done) rdata_q <= ram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_GRANT && req_ok) begin
      addr_l  <= hs_addr;
      wdata_l <= hs_wdata;
      we_l    <= hs_we;
    end
  end

  // One shared down-counter: settle time, read latency, then idle hold-off.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (req_ok) begin
          state_nx = S_PAUSE;
          cnt_nx   = SETTLE_LD;
        end
      end
      S_PAUSE: begin
        if (cnt == 8'd0) state_nx = S_GRANT;
        else             cnt_nx   = cnt - 8'd1;
      end
      S_GRANT: begin
        if (req_ok) begin
          state_nx = S_ACCESS;
          cnt_nx   = RD_LD;
        end else if (cnt == 8'd0) begin
          state_nx = S_RELEASE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      S_ACCESS: begin
        if (cnt == 8'd0) state_nx = S_ACK;
        else             cnt_nx   = cnt - 8'd1;
      end
      S_ACK: begin
        state_nx = S_GRANT;
        cnt_nx   = IDLE_LD;
      end
      S_RELEASE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (wd_trip) state_nx = S_RELEASE;
  end

  always_comb begin
    pause_cpu = paused;
    busy      = (state != S_IDLE);
    hs_ack    = 1'b0;
    wr_first  = 1'b0;
    rd_done   = 1'b0;
    case (state)
      S_ACCESS: wr_first = we_l && (cnt == RD_LD);
      S_ACK: begin
        hs_ack  = !wd_trip;
        rd_done = !we_l && !wd_trip;
      end
      default: ;
    endcase
  end

  // Read data is presented straight from the RAM during the ack cycle, then held.
  assign hs_rdata = rd_done ? ram_dout : rdata_q;
  assign cpu_dout = ram_dout;
  assign ram_addr = sel_hs ? addr_l   : cpu_addr;
  assign ram_din  = sel_hs ? wdata_l  : cpu_din;
  assign ram_we   = sel_hs ? wr_first : cpu_we;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Bench for hiscore_ram_arbiter: vector table, hand-written corner sequences and a randomized run against a timing/memory model.
module tb_hiscore_ram_arbiter;
  localparam int AW = 10, SETTLE = 4, RD_LAT = 1, IDLE_HOLD = 8;
`ifdef HISCORE_ARB_WATCHDOG_EN
  localparam logic [15:0] WD = 16'd20;
`else
  localparam logic [15:0] WD = 16'hFFFF;
`endif

  logic          clk, reset_n;
  logic [AW-1:0] cpu_addr, hs_addr, ram_addr;
  logic [7:0]    cpu_din, cpu_dout, hs_wdata, hs_rdata, ram_din, ram_dout;
  logic          cpu_we, hs_req, hs_we, hs_ack, ram_we, pause_cpu, busy, wd_error;

  hiscore_ram_arbiter #(.AW(AW), .SETTLE(SETTLE), .RD_LAT(RD_LAT), .IDLE_HOLD(IDLE_HOLD), .WD_LIMIT(WD)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
    .cpu_dout(cpu_dout), .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
    .hs_ack(hs_ack), .hs_rdata(hs_rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .pause_cpu(pause_cpu), .busy(busy), .wd_error(wd_error));

  int   cyc = 0, checks = 0, errors = 0;
  int   we_cnt = 0, ack_cnt = 0, rise_cyc = -1, fall_cyc = -1, fall_cnt = 0;
  int   we_q[$];
  bit   pause_prev = 0;
  logic [7:0] mem [0:1023];
  logic [7:0] exp_mem [0:1023];
  logic [7:0] rd_tmp;

  typedef struct {
    bit         we;
    logic [9:0] addr;
    logic [7:0] wdata;
    int         gap;
    bit         chk_rd;
    logic [7:0] exp_rd;
    int         exp_lat;
  } vec_t;
  vec_t vecs[8];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with one cycle of read latency.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h023] = 8'h0F;
    for (int i = 0; i < 32; i++) mem[10'h200 + i] = 8'(i * 7 + 3);
    ram_dout = 8'h00;
    forever begin
      @(posedge clk);
      rd_tmp = mem[ram_addr];
      if (ram_we) mem[ram_addr] = ram_din;
      ram_dout <= rd_tmp;
    end
  end

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt++;
      we_q.push_back(cyc);
    end
    if (hs_ack) ack_cnt++;
    if (pause_cpu && !pause_prev) rise_cyc = cyc;
    if (!pause_cpu && pause_prev) begin
      fall_cyc = cyc;
      fall_cnt++;
    end
    pause_prev = pause_cpu;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench timed out");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    check("idle_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Holds the request until ack, returns in the cycle after the ack with hs_req dropped.
  task automatic do_access(input bit we, input logic [9:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output int ack_c);
    hs_we = we; hs_addr = a; hs_wdata = d; hs_req = 1'b1;
    ack_c = -1;
    rd = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hs_ack) begin
        ack_c = cyc;
        rd = hs_rdata;
        break;
      end
    end
    check("ack_timeout", 32'(ack_c >= 0), 32'd1);
    @(posedge clk);
    #1;
    hs_req = 1'b0;
  endtask

  int         c0, c1, ack_c, ack2, wq0, fcnt0, ack0, last_ack, exp_ack, gap, wb, eff;
  logic [7:0] rd, last_rd, rw;
  logic [9:0] ra;
  bit         rwe;

  initial begin
    reset_n = 0; cpu_addr = 10'h3AB; cpu_din = 8'h11; cpu_we = 0;
    hs_req = 0; hs_we = 0; hs_addr = '0; hs_wdata = '0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) exp_mem[10'h200 + i] = 8'(i * 7 + 3);

    repeat (2) @(negedge clk);
    check("rst_pause", 32'(pause_cpu), 0);
    check("rst_ack", 32'(hs_ack), 0);
    check("rst_rdata", 32'(hs_rdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wd_error", 32'(wd_error), 0);
    check("rst_ram_addr", 32'(ram_addr), 32'h3AB);
    check("rst_ram_din", 32'(ram_din), 32'h11);
    check("rst_ram_we", 32'(ram_we), 0);
    @(posedge clk); #1;
    reset_n = 1;
    wait_cycles(2);

`ifndef HISCORE_ARB_WATCHDOG_EN
    // CPU write while idle
    cpu_addr = 10'h010; cpu_din = 8'h5A; cpu_we = 1;
    @(negedge clk);
    check("cpu_ram_we", 32'(ram_we), 1);
    check("cpu_ram_addr", 32'(ram_addr), 32'h010);
    @(posedge clk); #1;
    cpu_we = 0; cpu_addr = '0;
    @(negedge clk);
    check("cpu_mem_010", 32'(mem[10'h010]), 32'h5A);
    check("cpu_pause", 32'(pause_cpu), 0);
    check("cpu_dout_wire", 32'(cpu_dout), 32'(ram_dout));
    @(posedge clk); #1;

    // Single engine read from idle
    c0 = cyc;
    do_access(0, 10'h023, 8'h00, rd, ack_c);
    check("rd_pause_rise", 32'(rise_cyc - c0), 1);
    check("rd_ack_cycle", 32'(ack_c - c0), 7);
    check("rd_data", 32'(rd), 32'h0F);
    @(negedge clk);
    check("rd_data_held", 32'(hs_rdata), 32'h0F);
    check("rd_ack_single", 32'(hs_ack), 0);
    wait_idle();
    check("rd_release", 32'(fall_cyc - ack_c), 9);

    // Four back-to-back writes, then a re-request inside the hold-off window
    fcnt0 = fall_cnt; wq0 = we_q.size(); c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      do_access(1, 10'(10'h100 + k), 8'(8'h10 + k), rd, ack_c);
      if (k == 0) check("b2b_first_ack", 32'(ack_c - c0), 7);
    end
    check("b2b_we_count", 32'(we_q.size() - wq0), 4);
    check("b2b_first_we", 32'(we_q[wq0] - c0), 6);
    for (int k = 1; k < 4; k++) check("b2b_we_spacing", 32'(we_q[wq0 + k] - we_q[wq0 + k - 1]), 3);
    for (int k = 0; k < 4; k++) check("b2b_mem", 32'(mem[10'h100 + k]), 32'(8'h10 + k));
    check("b2b_no_drop", 32'(fall_cnt - fcnt0), 0);
    wait_cycles(2);
    c1 = cyc;
    do_access(0, 10'h102, 8'h00, rd, ack2);
    check("rereq_ack", 32'(ack2 - c1), 2);
    check("rereq_data", 32'(rd), 32'h12);
    check("rereq_no_drop", 32'(fall_cnt - fcnt0), 0);
    wait_idle();
    check("rereq_release", 32'(fall_cyc - ack2), 9);
    check("rereq_one_drop", 32'(fall_cnt - fcnt0), 1);

    // Reset during ACCESS
    ack0 = ack_cnt; c0 = cyc;
    hs_we = 1; hs_addr = 10'h150; hs_wdata = 8'h77; hs_req = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rstacc_in_access", 32'(ram_we), 1);
    check("rstacc_rdata_pre", 32'(hs_rdata), 32'h12);
    #1 reset_n = 0;
    hs_req = 0;
    #1;
    check("rstacc_pause", 32'(pause_cpu), 0);
    check("rstacc_busy", 32'(busy), 0);
    check("rstacc_ack", 32'(hs_ack), 0);
    check("rstacc_rdata", 32'(hs_rdata), 0);
    check("rstacc_ram_we", 32'(ram_we), 0);
    check("rstacc_ram_addr", 32'(ram_addr), 32'(cpu_addr));
    @(posedge clk); #1;
    reset_n = 1;
    wait_cycles(20);
    check("rstacc_no_ack", 32'(ack_cnt - ack0), 0);

    // Vector table: gaps are cycles after the previous op returns
    vecs[0] = '{1, 10'h300, 8'hA5, 0,  0, 8'h00, 7};
    vecs[1] = '{0, 10'h300, 8'h00, 0,  1, 8'hA5, 2};
    vecs[2] = '{1, 10'h301, 8'h3C, 4,  1, 8'hA5, 2};
    vecs[3] = '{0, 10'h301, 8'h00, 7,  1, 8'h3C, 2};
    vecs[4] = '{0, 10'h300, 8'h00, 8,  1, 8'hA5, 8};
    vecs[5] = '{1, 10'h302, 8'hFF, 20, 1, 8'hA5, 7};
    vecs[6] = '{0, 10'h302, 8'h00, 0,  1, 8'hFF, 2};
    vecs[7] = '{0, 10'h3FF, 8'h00, 0,  1, 8'h00, 2};
    for (int v = 0; v < 8; v++) begin
      wait_cycles(vecs[v].gap);
      c0 = cyc;
      do_access(vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, ack_c);
      check($sformatf("vec%0d_lat", v), 32'(ack_c - c0), 32'(vecs[v].exp_lat));
      if (vecs[v].chk_rd) check($sformatf("vec%0d_rdata", v), 32'(rd), 32'(vecs[v].exp_rd));
    end
    wait_idle();

    // Randomized accesses against the timing and memory model
    last_ack = -1000;
    last_rd = 8'h00;
    for (int n = 0; n < 40; n++) begin
      gap = int'($urandom_range(0, 12));
      rwe = 1'($urandom_range(0, 1));
      ra  = 10'(10'h200 + $urandom_range(0, 31));
      rw  = 8'($urandom);
      wait_cycles(gap);
      c0 = cyc;
      if (c0 <= last_ack + IDLE_HOLD) exp_ack = c0 + 1 + RD_LAT;
      else begin
        eff = (c0 > last_ack + IDLE_HOLD + 2) ? c0 : last_ack + IDLE_HOLD + 2;
        exp_ack = eff + 2 + SETTLE + RD_LAT;
      end
      wb = we_cnt;
      do_access(rwe, ra, rw, rd, ack_c);
      check($sformatf("rnd%0d_ack", n), 32'(ack_c), 32'(exp_ack));
      check($sformatf("rnd%0d_wecnt", n), 32'(we_cnt - wb), 32'(rwe));
      if (rwe) begin
        check($sformatf("rnd%0d_rd_held", n), 32'(rd), 32'(last_rd));
        exp_mem[ra] = rw;
      end else begin
        check($sformatf("rnd%0d_rdata", n), 32'(rd), 32'(exp_mem[ra]));
        last_rd = exp_mem[ra];
      end
      last_ack = ack_c;
    end
    wait_idle();
`else
    // Watchdog: request held forever
    c0 = cyc;
    hs_we = 0; hs_addr = 10'h023; hs_req = 1;
    wait_cycles(40);
    check("wd_pause_rise", 32'(rise_cyc - c0), 1);
    check("wd_pause_fall", 32'(fall_cyc - c0), 21);
    check("wd_error_set", 32'(wd_error), 1);
    @(negedge clk);
    check("wd_blocked_pause", 32'(pause_cpu), 0);
    check("wd_blocked_busy", 32'(busy), 0);
    @(posedge clk); #1;
    hs_req = 0;
    @(posedge clk); #1;
    hs_req = 1;
    wait_cycles(3);
    @(negedge clk);
    check("wd_regrant", 32'(pause_cpu), 1);
    check("wd_error_sticky", 32'(wd_error), 1);
    hs_req = 0;
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    check("wd_error_reset", 32'(wd_error), 0);
    reset_n = 1;
    wait_cycles(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
